tube_event_sequencer: RTL and testbench
=======================================

Name: tube_event_sequencer

Overview:
- Run-control FSM for the muon tube detector.
- On a scintillator coincidence it opens a timing window, drives the 20 ns stopwatch counter and latches each tube's first-hit time.
- It then serializes the per-tube times onto the 8-bit readout bus under a ready/ack handshake, and enforces a dead-time holdoff before re-arming.
- Sits between the front-end discriminator inputs and the tristate readout buffer.

Parameters:
- NUM_TUBES, 4: number of tube channels (1..64).
- CH_W, 2: channel index width, ceil(log2(NUM_TUBES)), minimum 1.
- WINDOW_LEN, 200: window length in clock ticks (1..255). Time values 0..WINDOW_LEN-1.
- HOLDOFF_CYC, 8: dead-time cycles after readout (0..255).
- NO_HIT, 8'hFF: sentinel time reported for a tube with no hit.

Ports:
- CLK  in  1  system clock, 50 MHz (20 ns tick).
- RST_N  in  1  synchronous reset, active low.
- SCIN_COINC  in  1  scintillator coincidence, level-sampled on posedge CLK.
- TUBE_IN  in  NUM_TUBES  discriminated tube signals, level-sampled.
- DATA_ACK  in  1  readout consumer accepts the current word.
- COUNTER  out  8  stopwatch value.
- DATA_OUT  out  8  tube time for channel CHAN_OUT.
- CHAN_OUT  out  CH_W  channel index of DATA_OUT.
- DATAREADY  out  1  DATA_OUT/CHAN_OUT valid; also the readout buffer enable.
- BUSY  out  1  high in any state other than IDLE.
- HIT_MASK  out  NUM_TUBES  bit i set if tube i hit in the current event.
- EVENT_CNT  out  8  accepted triggers, wraps 255 to 0.
- DROP_CNT  out  8  triggers ignored while BUSY, saturates at 255.

Behaviour:
- All outputs are registered.
- Reset (RST_N low at posedge) forces state IDLE on the next cycle:
  - COUNTER=0, DATA_OUT=0, CHAN_OUT=0, DATAREADY=0, BUSY=0.
  - HIT_MASK=0, all latched times=0, EVENT_CNT=0, DROP_CNT=0, holdoff counter=0.
  - Reset mid-window or mid-readout behaves identically; the partial event is discarded.
- IDLE:
  - COUNTER held at 0.
  - SCIN_COINC=1 at edge t: next state WINDOW, HIT_MASK cleared, EVENT_CNT+1.
  - Tube pulses during cycle t are not captured.
- WINDOW:
  - COUNTER=k in the (k+1)th window cycle; the first window cycle (t+1) shows COUNTER=0.
  - Each edge, for each i: if TUBE_IN[i]=1 and HIT_MASK[i]=0, latch time[i]=COUNTER and set HIT_MASK[i]. Capture is first-hit only; later pulses are ignored.
  - Simultaneous hits on several tubes all latch the same value.
  - At the edge where COUNTER=WINDOW_LEN-1: sampling still occurs, then next state READOUT with index=0, and COUNTER holds its final value.
- READOUT:
  - DATAREADY=1 from cycle t+1+WINDOW_LEN onward.
  - CHAN_OUT=index. DATA_OUT=time[index] if HIT_MASK[index], else NO_HIT.
  - One word transfers per edge where DATAREADY=1 and DATA_ACK=1.
  - If index<NUM_TUBES-1: index+1, and the next word is presented the following cycle with DATAREADY still 1.
  - If index=NUM_TUBES-1: next state HOLDOFF with DATAREADY=0.
  - DATA_ACK=0 stalls indefinitely with outputs held stable.
  - DATA_ACK while DATAREADY=0 is ignored.
- HOLDOFF:
  - Lasts HOLDOFF_CYC cycles, then IDLE, and COUNTER returns to 0.
  - HOLDOFF_CYC=0: the last ack goes directly to IDLE.
- SCIN_COINC=1 in WINDOW, READOUT or HOLDOFF: ignored, DROP_CNT+1 (saturating). It is sampled each cycle, so a held level counts once per cycle.
- The trigger edge that leaves IDLE is never counted as dropped.
- Widths:
  - COUNTER is 8 bits and cannot wrap, since WINDOW_LEN ≤ 255.
  - NO_HIT is never a legal time.

Test Plan:
- Basic event (WINDOW_LEN=10, HOLDOFF_CYC=2), stimulus:
  - SCIN_COINC pulse at cycle 0; TUBE_IN[2] high at cycle 4; TUBE_IN[0] high at cycles 7–9; DATA_ACK tied 1.
  - Required: words (ch0,6),(ch1,FF),(ch2,3),(ch3,FF) on cycles 11–14; BUSY low at cycle 17; EVENT_CNT=1.
- Simultaneous and repeated hits:
  - All tubes pulse at window COUNTER=5, then again at 8.
  - Required: all four words report 5; HIT_MASK=4'hF.
- Backpressure:
  - DATA_ACK low for 20 cycles after DATAREADY rises.
  - Required: ch0 word held stable for all 20 cycles; remaining words then transfer one per ack; exactly 4 transfers total.
- Dead-time triggers:
  - SCIN_COINC held high from the trigger through the end of HOLDOFF.
  - Required: EVENT_CNT=1; DROP_CNT = cycles busy (10 + 4 + 2 = 16 with ack tied 1); the next trigger is accepted in IDLE.
- Reset mid-readout:
  - RST_N low for 1 cycle after ch1 is acked.
  - Required: next cycle IDLE, DATAREADY=0, counters 0, HIT_MASK=0; a new trigger then runs normally.
- Edge window and saturation:
  - WINDOW_LEN=1, tube hit in the window cycle: reports time 0.
  - 300 dropped triggers: DROP_CNT=255.

Source files
------------

// File: rtl/tube_event_sequencer_if.sv
// Readout handshake between the sequencer (master) and the tristate readout buffer (slave).
interface tube_event_sequencer_if #(
  parameter int unsigned CH_W = 2
);
  logic [7:0]      DATA_OUT;
  logic [CH_W-1:0] CHAN_OUT;
  logic            DATAREADY;
  logic            DATA_ACK;

  modport master (output DATA_OUT, output CHAN_OUT, output DATAREADY, input DATA_ACK);
  modport slave  (input DATA_OUT, input CHAN_OUT, input DATAREADY, output DATA_ACK);
endinterface

// File: rtl/tube_event_sequencer.sv
// Muon tube run control: trigger, timing window with first-hit capture,
// word-by-word readout under ready/ack, then dead-time holdoff.
module tube_event_sequencer #(
  parameter int unsigned NUM_TUBES   = 4,
  parameter int unsigned CH_W        = 2,
  parameter int unsigned WINDOW_LEN  = 200,
  parameter int unsigned HOLDOFF_CYC = 8,
  parameter logic [7:0]  NO_HIT      = 8'hFF
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   SCIN_COINC,
  input  logic [NUM_TUBES-1:0]   TUBE_IN,
  tube_event_sequencer_if.master rd,
  output logic [7:0]             COUNTER,
  output logic                   BUSY,
  output logic [NUM_TUBES-1:0]   HIT_MASK,
  output logic [7:0]             EVENT_CNT,
  output logic [7:0]             DROP_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_WINDOW, S_READOUT, S_HOLDOFF} state_t;

  localparam logic [7:0]      LAST_TICK = 8'(WINDOW_LEN - 1);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_TUBES - 1);
  localparam logic [7:0]      HOLD_LAST = 8'(HOLDOFF_CYC - 1);

  state_t                r_state;
  logic [7:0]            r_counter;
  logic [7:0]            r_data_out;
  logic [CH_W-1:0]       r_chan;
  logic                  r_dataready;
  logic                  r_busy;
  logic [NUM_TUBES-1:0]  r_hit_mask;
  logic [7:0]            r_event_cnt;
  logic [7:0]            r_drop_cnt;
  logic [7:0]            r_hold;
  logic [7:0]            r_time [NUM_TUBES];

  logic [NUM_TUBES-1:0]  w_capture;
  logic [NUM_TUBES-1:0]  w_mask_nxt;
  logic [7:0]            w_time_nxt [NUM_TUBES];
  logic [CH_W-1:0]       w_sel;
  logic [7:0]            w_word;

  // The first readout word is loaded on the same edge as the last window
  // sample, so the word mux looks at the post-capture mask and times.
  always_comb begin
    w_capture  = (r_state == S_WINDOW) ? (TUBE_IN & ~r_hit_mask) : '0;
    w_mask_nxt = r_hit_mask | w_capture;
    for (int unsigned i = 0; i < NUM_TUBES; i++) begin
      w_time_nxt[i] = w_capture[i] ? r_counter : r_time[i];
    end
    w_sel  = (r_state == S_WINDOW) ? '0 : r_chan + CH_W'(1);
    w_word = w_mask_nxt[w_sel] ? w_time_nxt[w_sel] : NO_HIT;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_counter   <= '0;
      r_data_out  <= '0;
      r_chan      <= '0;
      r_dataready <= 1'b0;
      r_busy      <= 1'b0;
      r_hit_mask  <= '0;
      r_event_cnt <= '0;
      r_drop_cnt  <= '0;
      r_hold      <= '0;
      for (int unsigned i = 0; i < NUM_TUBES; i++) begin
        r_time[i] <= '0;
      end
    end else begin
      if (SCIN_COINC && (r_state != S_IDLE) && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (SCIN_COINC) begin
            r_state     <= S_WINDOW;
            r_busy      <= 1'b1;
            r_hit_mask  <= '0;
            r_counter   <= '0;
            r_event_cnt <= r_event_cnt + 8'd1;
          end
        end

        S_WINDOW: begin
          r_hit_mask <= w_mask_nxt;
          for (int unsigned i = 0; i < NUM_TUBES; i++) begin
            r_time[i] <= w_time_nxt[i];
          end
          if (r_counter == LAST_TICK) begin
            r_state     <= S_READOUT;
            r_chan      <= '0;
            r_data_out  <= w_word;
            r_dataready <= 1'b1;
          end else begin
            r_counter <= r_counter + 8'd1;
          end
        end

        S_READOUT: begin
          if (rd.DATA_ACK) begin
            if (r_chan == LAST_CH) begin
              r_dataready <= 1'b0;
              if (HOLDOFF_CYC == 0) begin
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_counter <= '0;
              end else begin
                r_state <= S_HOLDOFF;
                r_hold  <= HOLD_LAST;
              end
            end else begin
              r_chan     <= r_chan + CH_W'(1);
              r_data_out <= w_word;
            end
          end
        end

        S_HOLDOFF: begin
          if (r_hold == '0) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_counter <= '0;
          end else begin
            r_hold <= r_hold - 8'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign COUNTER      = r_counter;
  assign BUSY         = r_busy;
  assign HIT_MASK     = r_hit_mask;
  assign EVENT_CNT    = r_event_cnt;
  assign DROP_CNT     = r_drop_cnt;
  assign rd.DATA_OUT  = r_data_out;
  assign rd.CHAN_OUT  = r_chan;
  assign rd.DATAREADY = r_dataready;

endmodule

// File: tb/tb_tube_event_sequencer.sv
// Bench for tube_event_sequencer: event-level reference model (first in-window
// hit per tube, busy span from window length, acks and holdoff) plus directed edge cases.
module tb_tube_event_sequencer;

  localparam int unsigned WL = 10;
  localparam int unsigned HL = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  // DUT A: WINDOW_LEN=10, HOLDOFF_CYC=2
  logic       scin_a;
  logic [3:0] tube_a;
  logic [7:0] counter_a, ev_a, drop_a;
  logic       busy_a;
  logic [3:0] hit_a;
  tube_event_sequencer_if #(.CH_W(2)) rd_a ();

  tube_event_sequencer #(
    .NUM_TUBES(4), .CH_W(2), .WINDOW_LEN(WL), .HOLDOFF_CYC(HL), .NO_HIT(8'hFF)
  ) dut_a (
    .CLK(clk), .RST_N(rst_n), .SCIN_COINC(scin_a), .TUBE_IN(tube_a), .rd(rd_a),
    .COUNTER(counter_a), .BUSY(busy_a), .HIT_MASK(hit_a),
    .EVENT_CNT(ev_a), .DROP_CNT(drop_a)
  );

  // DUT B: one-tick window, no holdoff
  logic       scin_b;
  logic [3:0] tube_b;
  logic [7:0] counter_b, ev_b, drop_b;
  logic       busy_b;
  logic [3:0] hit_b;
  tube_event_sequencer_if #(.CH_W(2)) rd_b ();

  tube_event_sequencer #(
    .NUM_TUBES(4), .CH_W(2), .WINDOW_LEN(1), .HOLDOFF_CYC(0), .NO_HIT(8'hFF)
  ) dut_b (
    .CLK(clk), .RST_N(rst_n), .SCIN_COINC(scin_b), .TUBE_IN(tube_b), .rd(rd_b),
    .COUNTER(counter_b), .BUSY(busy_b), .HIT_MASK(hit_b),
    .EVENT_CNT(ev_b), .DROP_CNT(drop_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_ev     = 0;
  int m_drop   = 0;
  logic [3:0] pat [0:WL];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit rnd(input int unsigned pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic drive_scin(input bit s);
    scin_a = s;
    if (s) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
  endtask

  task automatic random_pattern();
    for (int k = 0; k <= int'(WL); k++) pat[k] = 4'($urandom & $urandom & $urandom);
  endtask

  // One full event on DUT A using pat[]; offset 0 is the trigger cycle.
  task automatic run_event(input int unsigned ack_pct, input int stall, input int unsigned scin_pct);
    logic [7:0] exp_t [4];
    logic [3:0] exp_mask;
    int         j, o, xfers;
    bit         a;

    exp_mask = '0;
    for (int i = 0; i < 4; i++) begin
      exp_t[i] = 8'hFF;
      for (int k = int'(WL); k >= 1; k--) begin
        if (pat[k][i]) begin
          exp_t[i]    = 8'(k - 1);
          exp_mask[i] = 1'b1;
        end
      end
    end
    m_ev = (m_ev + 1) % 256;

    @(negedge clk);
    chk("idle_busy", busy_a, 0);
    chk("idle_counter", counter_a, 0);
    chk("idle_dataready", rd_a.DATAREADY, 0);
    scin_a = 1'b1;
    tube_a = pat[0];
    rd_a.DATA_ACK = 1'($urandom_range(1));

    for (o = 1; o <= int'(WL); o++) begin
      @(negedge clk);
      chk("win_counter", counter_a, o - 1);
      chk("win_busy", busy_a, 1);
      chk("win_dataready", rd_a.DATAREADY, 0);
      drive_scin(rnd(scin_pct));
      tube_a = pat[o];
      rd_a.DATA_ACK = 1'($urandom_range(1));
    end

    j = 0; o = 0; xfers = 0;
    while (j < 4 && o < stall + 200) begin
      @(negedge clk);
      chk("rd_dataready", rd_a.DATAREADY, 1);
      chk("rd_chan", rd_a.CHAN_OUT, j);
      chk("rd_data", rd_a.DATA_OUT, exp_t[j]);
      chk("rd_mask", hit_a, exp_mask);
      chk("rd_counter", counter_a, WL - 1);
      a = (o >= stall) && rnd(ack_pct);
      rd_a.DATA_ACK = a;
      tube_a = 4'($urandom);
      drive_scin(rnd(scin_pct));
      if (a) begin
        j++;
        if (rd_a.DATAREADY) xfers++;
      end
      o++;
    end
    chk("rd_words_acked", j, 4);

    for (int h = 0; h < int'(HL); h++) begin
      @(negedge clk);
      chk("hold_busy", busy_a, 1);
      chk("hold_dataready", rd_a.DATAREADY, 0);
      chk("hold_counter", counter_a, WL - 1);
      drive_scin(rnd(scin_pct));
      rd_a.DATA_ACK = 1'($urandom_range(1));
      tube_a = 4'($urandom);
    end

    @(negedge clk);
    scin_a = 1'b0; tube_a = '0; rd_a.DATA_ACK = 1'b0;
    chk("end_busy", busy_a, 0);
    chk("end_dataready", rd_a.DATAREADY, 0);
    chk("end_counter", counter_a, 0);
    chk("end_transfers", xfers, 4);
    chk("end_event_cnt", ev_a, m_ev);
    chk("end_drop_cnt", drop_a, m_drop);
  endtask

  initial begin
    rst_n = 1'b0;
    scin_a = 1'b0; tube_a = '0; rd_a.DATA_ACK = 1'b0;
    scin_b = 1'b0; tube_b = '0; rd_b.DATA_ACK = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_counter", counter_a, 0);
    chk("rst_data", rd_a.DATA_OUT, 0);
    chk("rst_chan", rd_a.CHAN_OUT, 0);
    chk("rst_dataready", rd_a.DATAREADY, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_mask", hit_a, 0);
    chk("rst_event_cnt", ev_a, 0);
    chk("rst_drop_cnt", drop_a, 0);
    chk("rst_b_busy", busy_b, 0);

    // Basic event: tube2 at cycle 4, tube0 at cycles 7..9, ack tied high
    for (int k = 0; k <= int'(WL); k++) pat[k] = '0;
    pat[4] = 4'b0100;
    pat[7] = 4'b0001; pat[8] = 4'b0001; pat[9] = 4'b0001;
    run_event(100, 0, 0);

    // All tubes at COUNTER=5 and again at COUNTER=8
    for (int k = 0; k <= int'(WL); k++) pat[k] = '0;
    pat[6] = 4'hF; pat[9] = 4'hF;
    run_event(100, 0, 0);

    // Backpressure: ack withheld 20 cycles
    random_pattern();
    run_event(100, 20, 0);

    // Randomized events with random acks and stray triggers
    for (int n = 0; n < 8; n++) begin
      random_pattern();
      run_event(60, 0, 25);
    end

    // Reset right after ch1 is acked
    @(negedge clk);
    scin_a = 1'b1; rd_a.DATA_ACK = 1'b0; tube_a = '0;
    @(negedge clk);
    scin_a = 1'b0; tube_a = 4'b1010;
    repeat (WL) begin
      @(negedge clk);
      tube_a = '0;
    end
    chk("mid_rd_chan0", rd_a.CHAN_OUT, 0);
    rd_a.DATA_ACK = 1'b1;
    @(negedge clk);
    chk("mid_rd_chan1", rd_a.CHAN_OUT, 1);
    @(negedge clk);
    chk("mid_rd_chan2", rd_a.CHAN_OUT, 2);
    rd_a.DATA_ACK = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_dataready", rd_a.DATAREADY, 0);
    chk("mid_rst_counter", counter_a, 0);
    chk("mid_rst_mask", hit_a, 0);
    chk("mid_rst_event_cnt", ev_a, 0);
    chk("mid_rst_drop_cnt", drop_a, 0);
    m_ev = 0; m_drop = 0;

    // Trigger level held through the whole busy span
    random_pattern();
    run_event(100, 0, 100);
    chk("dead_drop_16", drop_a, 16);
    chk("dead_event_1", ev_a, 1);
    random_pattern();
    run_event(100, 0, 0);

    // Long stall with trigger held: drop counter saturates
    random_pattern();
    run_event(100, 300, 100);
    chk("drop_saturated", drop_a, 255);

    // One-tick window, zero holdoff on DUT B
    @(negedge clk);
    scin_b = 1'b1; tube_b = 4'b0001; rd_b.DATA_ACK = 1'b1;
    @(negedge clk);
    chk("b_win_counter", counter_b, 0);
    chk("b_win_busy", busy_b, 1);
    chk("b_win_dataready", rd_b.DATAREADY, 0);
    scin_b = 1'b0; tube_b = 4'b0010;
    @(negedge clk);
    tube_b = 4'b0001;
    chk("b_w0_dataready", rd_b.DATAREADY, 1);
    chk("b_w0_chan", rd_b.CHAN_OUT, 0);
    chk("b_w0_data", rd_b.DATA_OUT, 8'hFF);
    @(negedge clk);
    chk("b_w1_chan", rd_b.CHAN_OUT, 1);
    chk("b_w1_data", rd_b.DATA_OUT, 0);
    chk("b_mask", hit_b, 4'b0010);
    @(negedge clk);
    chk("b_w2_data", rd_b.DATA_OUT, 8'hFF);
    @(negedge clk);
    chk("b_w3_chan", rd_b.CHAN_OUT, 3);
    @(negedge clk);
    rd_b.DATA_ACK = 1'b0; tube_b = '0;
    chk("b_end_busy", busy_b, 0);
    chk("b_end_dataready", rd_b.DATAREADY, 0);
    chk("b_end_counter", counter_b, 0);
    chk("b_event_cnt", ev_b, 1);
    chk("b_drop_cnt", drop_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
